bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of bus requesters.
REQ-002 Parameter: NUNIT, 10, number of bus units (tri-state drivers / register loads).
REQ-003 Parameter: MAXHOLD, 8, maximum consecutive locked cycles for one owner.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 req  input  NREQ  per-requester bus request.
REQ-007 lock  input  NREQ  per-requester hold-bus-after-transfer request.
REQ-008 src  input  4*NREQ  per-requester binary source unit code (slice i = requester i).
REQ-009 dst  input  4*NREQ  per-requester binary destination unit code.
REQ-010 gnt  output  NREQ  one-hot grant; zero when idle.
REQ-011 tri_en_OH  output  NUNIT  one-hot tri-state driver enable for the shared bus.
REQ-012 r_en_OH  output  NUNIT  one-hot register load enable.
REQ-013 busy  output  1  high while any grant is active.
REQ-014 err  output  1  one-cycle pulse on an illegal transfer request.

Function
REQ-015 States SHALL be IDLE, XFER, LOCK; encoding in the shared package.
REQ-016 IDLE: if any req high at an edge, SHALL go XFER with gnt registered to the round-robin winner; else stay IDLE.
REQ-017 Latency: req sampled at edge t, gnt/tri_en_OH/r_en_OH valid in the cycle after edge t; one transfer per XFER cycle.
REQ-018 Round-robin: after granting requester i, priority order SHALL be i+1, i+2, ... wrapping modulo NREQ; pointer resets to requester 0 having top priority.
REQ-019 XFER: tri_en_OH = onehot(src of owner), r_en_OH = onehot(dst of owner), both combinational from the registered owner and current src/dst.
REQ-020 XFER exit: owner lock high -> LOCK, same owner; else re-arbitrate: any req (including owner) -> XFER with next winner, none -> IDLE.
REQ-021 LOCK: gnt held, tri_en_OH/r_en_OH held zero; hold counter increments each LOCK cycle.
REQ-022 LOCK exit: owner req high -> XFER same owner; owner lock low and req low -> re-arbitrate as REQ-020; counter reaching MAXHOLD -> forced release, re-arbitrate excluding the owner for that one decision.
REQ-023 Owner dropping req in XFER with lock low: gnt SHALL drop at the next edge.
REQ-024 Illegal code: src or dst >= NUNIT, or src == dst -> that cycle's tri_en_OH and r_en_OH SHALL be all zero, err pulses one cycle, state advances normally.
REQ-025 At most one bit of gnt, tri_en_OH, r_en_OH SHALL be high in any cycle.
REQ-026 busy = (state != IDLE).

Reset
REQ-027 rst low at an edge SHALL force IDLE, gnt=0, pointer=0, hold counter=0, err=0; tri_en_OH=r_en_OH=0 the following cycle.
REQ-028 Reset mid-XFER or mid-LOCK SHALL abort the transfer with no further enables asserted.

Structure
REQ-029 Shared package SHALL hold the state encoding, NREQ/NUNIT/MAXHOLD defaults, and the unit-code width (4).
REQ-030 Binary-to-one-hot decoding SHALL reuse the existing binary_to_onehot module (two instances); round-robin pick SHALL be a sub-module rr_picker (req, pointer -> one-hot winner).

Verification
REQ-031 Single req[2], src=3, dst=5, lock=0 -> next cycle gnt=0100, tri_en_OH bit3, r_en_OH bit5, busy=1; then IDLE.
REQ-032 req=1111 held 8 cycles, no lock -> gnt sequence 0001,0010,0100,1000,0001,... after reset.
REQ-033 req[1] with lock held high, req[1] low after first XFER, req[0] high -> 8 LOCK cycles, forced release, gnt=0001 next.
REQ-034 req[0] with src=12 -> err pulse, tri_en_OH=r_en_OH=0; src=dst=4 -> same.
REQ-035 rst low during LOCK with req/lock high -> next cycle gnt=0, busy=0, pointer restarts at requester 0.
REQ-036 Random req/lock/src/dst 10k cycles -> one-hot invariants of REQ-025 never violated.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding, default sizes
// and the width of a binary unit code.
package bus_arbiter_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int NUNIT_DEF   = 10;
  localparam int MAXHOLD_DEF = 8;
  localparam int UNIT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    LOCK = 2'd2
  } state_t;

endpackage

// File: rtl/bus_arbiter_binary_to_onehot.sv
// Binary code to one-hot decoder; codes outside 0..N-1 decode to all zero.
module binary_to_onehot #(
  parameter int IN_W = 4,
  parameter int N    = 10
) (
  input  logic [IN_W-1:0] bin,
  output logic [N-1:0]    onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(bin) == i) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: returns the one-hot first requester found when scanning
// upward from ptr, wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner
);

  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: round-robin grant, one transfer per XFER cycle, optional
// bounded bus locking, and one-hot driver/load enables for the granted transfer.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int NUNIT   = NUNIT_DEF,
  parameter int MAXHOLD = MAXHOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [UNIT_W*NREQ-1:0]   src,
  input  logic [UNIT_W*NREQ-1:0]   dst,
  output logic [NREQ-1:0]          gnt,
  output logic [NUNIT-1:0]         tri_en_OH,
  output logic [NUNIT-1:0]         r_en_OH,
  output logic                     busy,
  output logic                     err
);

  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HOLD_W = $clog2(MAXHOLD + 1);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NREQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAXHOLD - 1);
  localparam logic [UNIT_W:0]   NUNIT_L   = (UNIT_W + 1)'(NUNIT);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [UNIT_W-1:0] owner_src, owner_dst;
  logic              owner_req, owner_lock;
  logic              force_rel, illegal, xfer_ok;
  logic [NREQ-1:0]   arb_req, win_oh;
  logic [PTR_W-1:0]  win_idx;
  logic [NUNIT-1:0]  src_oh, dst_oh;
  logic              arb;

  always_comb begin
    owner_src  = '0;
    owner_dst  = '0;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        owner_src  = src[i*UNIT_W +: UNIT_W];
        owner_dst  = dst[i*UNIT_W +: UNIT_W];
        owner_req  = req[i];
        owner_lock = lock[i];
      end
    end
  end

  // A forced release hides the current owner from that one arbitration.
  assign force_rel = (state_q == LOCK) && (hold_q == HOLD_LAST);
  assign arb_req   = force_rel ? (req & ~gnt_q) : req;

  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req    (arb_req),
    .ptr    (ptr_q),
    .winner (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) win_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = '0;
    arb     = 1'b0;
    case (state_q)
      IDLE: arb = 1'b1;
      XFER: begin
        if (owner_lock) state_d = LOCK;
        else            arb     = 1'b1;
      end
      LOCK: begin
        if (force_rel)        arb     = 1'b1;
        else if (owner_req)   state_d = XFER;
        else if (!owner_lock) arb     = 1'b1;
        else                  hold_d  = hold_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      if (|win_oh) begin
        state_d = XFER;
        gnt_d   = win_oh;
        owner_d = win_idx;
        ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  binary_to_onehot #(.IN_W(UNIT_W), .N(NUNIT)) u_src_dec (.bin(owner_src), .onehot(src_oh));
  binary_to_onehot #(.IN_W(UNIT_W), .N(NUNIT)) u_dst_dec (.bin(owner_dst), .onehot(dst_oh));

  assign illegal   = ({1'b0, owner_src} >= NUNIT_L) || ({1'b0, owner_dst} >= NUNIT_L) ||
                     (owner_src == owner_dst);
  assign xfer_ok   = (state_q == XFER) && !illegal;
  assign tri_en_OH = xfer_ok ? src_oh : '0;
  assign r_en_OH   = xfer_ok ? dst_oh : '0;
  assign err       = (state_q == XFER) && illegal;
  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int NREQ    = NREQ_DEF;
  localparam int NUNIT   = NUNIT_DEF;
  localparam int MAXHOLD = MAXHOLD_DEF;
  localparam int VW      = UNIT_W * NREQ;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, lock;
  logic [VW-1:0]   src, dst;
  logic [NREQ-1:0] gnt;
  logic [NUNIT-1:0] tri_en_OH, r_en_OH;
  logic            busy, err;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = transfer, 2 = locked
  int m_state = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.NREQ(NREQ), .NUNIT(NUNIT), .MAXHOLD(MAXHOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .src       (src),
    .dst       (dst),
    .gnt       (gnt),
    .tri_en_OH (tri_en_OH),
    .r_en_OH   (r_en_OH),
    .busy      (busy),
    .err       (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic int unitOf(input logic [VW-1:0] v, input int i);
    logic [UNIT_W-1:0] u;
    u = v[i*UNIT_W +: UNIT_W];
    return int'(u);
  endfunction

  function automatic bit bitOf(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [VW-1:0] allUnits(input int u);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) v[i*UNIT_W +: UNIT_W] = UNIT_W'(u);
    return v;
  endfunction

  function automatic int pickModel(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (bitOf(r, (m_ptr + k) % NREQ)) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic modelStep();
    int w;
    bit doArb;
    logic [NREQ-1:0] cand;
    if (!rst) begin
      m_state = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_valid = 1'b1;
      return;
    end
    doArb = 1'b0;
    cand  = req;
    case (m_state)
      0: doArb = 1'b1;
      1: begin
        if (bitOf(lock, m_owner)) begin m_state = 2; m_hold = 0; end
        else doArb = 1'b1;
      end
      default: begin
        m_hold++;
        if (m_hold == MAXHOLD) begin
          doArb = 1'b1;
          cand  = req & ~(NREQ'(1) << m_owner);
        end else if (bitOf(req, m_owner)) m_state = 1;
        else if (!bitOf(lock, m_owner)) doArb = 1'b1;
      end
    endcase
    if (doArb) begin
      w = pickModel(cand);
      if (w < 0) m_state = 0;
      else begin m_state = 1; m_owner = w; m_ptr = (w + 1) % NREQ; end
    end
    if (m_state != 2) m_hold = 0;
  endtask

  task automatic checkModel();
    int s, d;
    bit legal;
    logic [31:0] eg, et, er;
    s     = unitOf(src, m_owner);
    d     = unitOf(dst, m_owner);
    legal = (s < NUNIT) && (d < NUNIT) && (s != d);
    eg    = (m_state == 0) ? 32'd0 : (32'd1 << m_owner);
    et    = (m_state == 1 && legal) ? (32'd1 << s) : 32'd0;
    er    = (m_state == 1 && legal) ? (32'd1 << d) : 32'd0;
    checkOutput("gnt", 32'(gnt), eg);
    checkOutput("tri_en", 32'(tri_en_OH), et);
    checkOutput("r_en", 32'(r_en_OH), er);
    checkOutput("busy", 32'(busy), 32'(m_state != 0));
    checkOutput("err", 32'(err), 32'(m_state == 1 && !legal));
    checkOutput("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    checkOutput("tri_onehot", 32'($countones(tri_en_OH) <= 1), 32'd1);
    checkOutput("ren_onehot", 32'($countones(r_en_OH) <= 1), 32'd1);
  endtask

  // Drive one cycle of inputs, compare against the model mid-cycle, then
  // advance the model on the rising edge.
  task automatic applyStimulus(input logic rst_v, input logic [NREQ-1:0] req_v,
                               input logic [NREQ-1:0] lock_v, input logic [VW-1:0] src_v,
                               input logic [VW-1:0] dst_v);
    @(negedge clk);
    rst = rst_v; req = req_v; lock = lock_v; src = src_v; dst = dst_v;
    #1;
    if (m_valid) checkModel();
    @(posedge clk);
    #1;
    modelStep();
  endtask

  function automatic logic [UNIT_W-1:0] randUnit();
    if ($urandom_range(0, 7) == 0) return UNIT_W'($urandom_range(0, 15));
    return UNIT_W'($urandom_range(0, NUNIT - 1));
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [VW-1:0] rs, rd;
    logic [NREQ-1:0] rq, lk;
    rst = 1'b0; req = '0; lock = '0; src = '0; dst = '0;

    applyStimulus(1'b0, '0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0, '0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tri", 32'(tri_en_OH), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);

    // Single transfer from requester 2, unit 3 to unit 5
    applyStimulus(1'b1, 4'b0100, '0, allUnits(3), allUnits(5));
    checkOutput("single_gnt", 32'(gnt), 32'h4);
    checkOutput("single_tri", 32'(tri_en_OH), 32'h8);
    checkOutput("single_ren", 32'(r_en_OH), 32'h20);
    checkOutput("single_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, '0, '0, allUnits(3), allUnits(5));
    checkOutput("single_idle", 32'(busy), 32'd0);
    checkOutput("single_gnt0", 32'(gnt), 32'd0);

    // Full contention rotates through all requesters
    applyStimulus(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'hF, '0, allUnits(1), allUnits(2));
      checkOutput("rr_seq", 32'(gnt), 32'd1 << (i % NREQ));
    end

    // Locked owner with its request withdrawn is released after MAXHOLD cycles
    applyStimulus(1'b0, '0, '0, '0, '0);
    applyStimulus(1'b1, 4'b0010, 4'b0010, allUnits(1), allUnits(2));
    checkOutput("lock_xfer", 32'(gnt), 32'h2);
    applyStimulus(1'b1, 4'b0001, 4'b0010, allUnits(1), allUnits(2));
    checkOutput("lock_gnt", 32'(gnt), 32'h2);
    checkOutput("lock_tri", 32'(tri_en_OH), 32'd0);
    for (int k = 1; k <= MAXHOLD; k++) begin
      applyStimulus(1'b1, 4'b0001, 4'b0010, allUnits(1), allUnits(2));
      if (k < MAXHOLD) checkOutput("lock_hold", 32'(gnt), 32'h2);
      else             checkOutput("forced_release", 32'(gnt), 32'h1);
    end

    // Illegal unit codes: out of range, then source equal to destination
    applyStimulus(1'b0, '0, '0, '0, '0);
    applyStimulus(1'b1, 4'b0001, '0, allUnits(12), allUnits(5));
    checkOutput("ill_range_err", 32'(err), 32'd1);
    checkOutput("ill_range_tri", 32'(tri_en_OH), 32'd0);
    checkOutput("ill_range_ren", 32'(r_en_OH), 32'd0);
    applyStimulus(1'b1, 4'b0001, '0, allUnits(4), allUnits(4));
    checkOutput("ill_same_err", 32'(err), 32'd1);
    checkOutput("ill_same_tri", 32'(tri_en_OH), 32'd0);
    checkOutput("ill_same_ren", 32'(r_en_OH), 32'd0);

    // Reset while locked aborts and restarts the pointer at requester 0
    applyStimulus(1'b0, '0, '0, '0, '0);
    applyStimulus(1'b1, 4'b0010, 4'b0010, allUnits(1), allUnits(2));
    applyStimulus(1'b1, 4'b0001, 4'b0010, allUnits(1), allUnits(2));
    applyStimulus(1'b0, 4'hF, 4'hF, allUnits(1), allUnits(2));
    checkOutput("rst_lock_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_lock_busy", 32'(busy), 32'd0);
    checkOutput("rst_lock_tri", 32'(tri_en_OH), 32'd0);
    applyStimulus(1'b1, 4'hF, '0, allUnits(1), allUnits(2));
    checkOutput("rst_ptr", 32'(gnt), 32'h1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 10000; c++) begin
      rq = NREQ'($urandom_range(0, 15));
      lk = ($urandom_range(0, 2) == 0) ? NREQ'($urandom_range(0, 15)) : '0;
      for (int i = 0; i < NREQ; i++) begin
        rs[i*UNIT_W +: UNIT_W] = randUnit();
        rd[i*UNIT_W +: UNIT_W] = randUnit();
      end
      applyStimulus(($urandom_range(0, 199) != 0), rq, lk, rs, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
